// File: rtl/execute_stage_if.sv
// ID/EX bundle between InstructionDecode (master) and execute_stage (slave).
// The master drives the decoded instruction, the stall/halt controls and the MEM/WB
// forwarding sources. The slave returns the execute results, the redirect and halt_EX.
// Write enables (RWEN/DWEN) are active-low throughout.
interface execute_stage_if;
  // decode -> execute
  logic [31:0] ID_PC, ID_DataRS1, ID_DataRS2;
  logic [31:0] ID_imm_I, ID_imm_S, ID_imm_SB, ID_imm_U, ID_imm_UJ;
  logic [6:0]  ID_opcode, ID_funct7;
  logic [2:0]  ID_funct3;
  logic [4:0]  ID_rs1, ID_rs2, ID_rd;
  logic        ID_RWEN, ID_DWEN, ID_MEMREAD, ID_BRANCH_OR_JUMP;
  logic        EX_stall, halt_MEM;
  // forwarding sources
  logic [4:0]  MEM_rd, WB_rd;
  logic        MEM_RWEN, WB_RWEN;
  logic [31:0] MEM_ALUResult, WB_DataInRd;
  // execute -> downstream / fetch
  logic [31:0] EX_ALUResult, EX_DataRS2;
  logic [4:0]  EX_rd;
  logic [2:0]  EX_funct3;
  logic [1:0]  EX_DataSize;
  logic        EX_RWEN, EX_DWEN, EX_MEMREAD, EX_BRANCH_OR_JUMP;
  logic        branch_flag;
  logic [31:0] branch_or_jump_target_addr;
  logic        halt_EX;

  modport master (
    output ID_PC, ID_DataRS1, ID_DataRS2, ID_imm_I, ID_imm_S, ID_imm_SB, ID_imm_U, ID_imm_UJ,
           ID_opcode, ID_funct7, ID_funct3, ID_rs1, ID_rs2, ID_rd,
           ID_RWEN, ID_DWEN, ID_MEMREAD, ID_BRANCH_OR_JUMP, EX_stall, halt_MEM,
           MEM_rd, MEM_RWEN, MEM_ALUResult, WB_rd, WB_RWEN, WB_DataInRd,
    input  EX_ALUResult, EX_DataRS2, EX_rd, EX_funct3, EX_DataSize, EX_RWEN, EX_DWEN,
           EX_MEMREAD, EX_BRANCH_OR_JUMP, branch_flag, branch_or_jump_target_addr, halt_EX
  );

  modport slave (
    input  ID_PC, ID_DataRS1, ID_DataRS2, ID_imm_I, ID_imm_S, ID_imm_SB, ID_imm_U, ID_imm_UJ,
           ID_opcode, ID_funct7, ID_funct3, ID_rs1, ID_rs2, ID_rd,
           ID_RWEN, ID_DWEN, ID_MEMREAD, ID_BRANCH_OR_JUMP, EX_stall, halt_MEM,
           MEM_rd, MEM_RWEN, MEM_ALUResult, WB_rd, WB_RWEN, WB_DataInRd,
    output EX_ALUResult, EX_DataRS2, EX_rd, EX_funct3, EX_DataSize, EX_RWEN, EX_DWEN,
           EX_MEMREAD, EX_BRANCH_OR_JUMP, branch_flag, branch_or_jump_target_addr, halt_EX
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX pipeline register plus ALU, address generation, branch/jump
// resolution and MEM/WB operand forwarding.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous active-high reset
//   bus  - execute_stage_if.slave: decoded instruction in, results/redirect/halt out
// Outputs are combinational from the EX register and the forwarding inputs.
module execute_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_sb;
    logic [31:0] imm_u;
    logic [31:0] imm_uj;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rwen;
    logic        dwen;
    logic        memread;
    logic        boj;
  } ex_t;

  ex_t ex_q, ex_d, ex_bubble, ex_in;

  logic [31:0] rs1_fwd, rs2_fwd, op_b, alu_result, target;
  logic [4:0]  shamt;
  logic        alt, unsupported, cond, taken, halt_ex;

  // Only funct7[5] selects SUB/SRA; the rest of the field is carried but unused.
  logic unused_funct7;
  assign unused_funct7 = ^{ex_q.funct7[6], ex_q.funct7[4:0]};

  always_comb begin
    ex_bubble    = '0;
    ex_bubble.pc = RESET_PC;
  end

  always_comb begin
    ex_in          = '0;
    ex_in.valid    = 1'b1;
    ex_in.pc       = bus.ID_PC;
    ex_in.rs1_data = bus.ID_DataRS1;
    ex_in.rs2_data = bus.ID_DataRS2;
    ex_in.imm_i    = bus.ID_imm_I;
    ex_in.imm_s    = bus.ID_imm_S;
    ex_in.imm_sb   = bus.ID_imm_SB;
    ex_in.imm_u    = bus.ID_imm_U;
    ex_in.imm_uj   = bus.ID_imm_UJ;
    ex_in.opcode   = bus.ID_opcode;
    ex_in.funct7   = bus.ID_funct7;
    ex_in.funct3   = bus.ID_funct3;
    ex_in.rs1      = bus.ID_rs1;
    ex_in.rs2      = bus.ID_rs2;
    ex_in.rd       = bus.ID_rd;
    ex_in.rwen     = bus.ID_RWEN;
    ex_in.dwen     = bus.ID_DWEN;
    ex_in.memread  = bus.ID_MEMREAD;
    ex_in.boj      = bus.ID_BRANCH_OR_JUMP;
  end

  // Hold on any halt; a redirect squashes whatever decode presents on the same edge.
  always_comb begin
    ex_d = ex_q;
    if (halt_ex || bus.halt_MEM) begin
      ex_d = ex_q;
    end else if (taken || bus.EX_stall) begin
      ex_d = ex_bubble;
    end else begin
      ex_d = ex_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= ex_bubble;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding: MEM beats WB, x0 never forwards.
  always_comb begin
    rs1_fwd = ex_q.rs1_data;
    if (!bus.MEM_RWEN && bus.MEM_rd != 5'd0 && bus.MEM_rd == ex_q.rs1) begin
      rs1_fwd = bus.MEM_ALUResult;
    end else if (!bus.WB_RWEN && bus.WB_rd != 5'd0 && bus.WB_rd == ex_q.rs1) begin
      rs1_fwd = bus.WB_DataInRd;
    end
    rs2_fwd = ex_q.rs2_data;
    if (!bus.MEM_RWEN && bus.MEM_rd != 5'd0 && bus.MEM_rd == ex_q.rs2) begin
      rs2_fwd = bus.MEM_ALUResult;
    end else if (!bus.WB_RWEN && bus.WB_rd != 5'd0 && bus.WB_rd == ex_q.rs2) begin
      rs2_fwd = bus.WB_DataInRd;
    end
  end

  assign op_b  = (ex_q.opcode == OpReg) ? rs2_fwd : ex_q.imm_i;
  assign shamt = op_b[4:0];
  assign alt   = ex_q.funct7[5];

  always_comb begin
    alu_result = 32'd0;
    case (ex_q.opcode)
      OpLui:          alu_result = ex_q.imm_u;
      OpAuipc:        alu_result = ex_q.pc + ex_q.imm_u;
      OpJal, OpJalr:  alu_result = ex_q.pc + 32'd4;
      OpLoad:         alu_result = rs1_fwd + ex_q.imm_i;
      OpStore:        alu_result = rs1_fwd + ex_q.imm_s;
      OpImm, OpReg: begin
        case (ex_q.funct3)
          3'b000: alu_result = (ex_q.opcode == OpReg && alt) ? rs1_fwd - op_b : rs1_fwd + op_b;
          3'b001: alu_result = rs1_fwd << shamt;
          3'b010: alu_result = {31'd0, $signed(rs1_fwd) < $signed(op_b)};
          3'b011: alu_result = {31'd0, rs1_fwd < op_b};
          3'b100: alu_result = rs1_fwd ^ op_b;
          3'b101: alu_result = alt ? $unsigned($signed(rs1_fwd) >>> shamt) : rs1_fwd >> shamt;
          3'b110: alu_result = rs1_fwd | op_b;
          default: alu_result = rs1_fwd & op_b;
        endcase
      end
      default:        alu_result = 32'd0;
    endcase
  end

  always_comb begin
    unsupported = 1'b0;
    case (ex_q.opcode)
      OpLui, OpAuipc, OpJal, OpJalr, OpLoad, OpStore, OpImm, OpReg: unsupported = 1'b0;
      OpBranch: unsupported = (ex_q.funct3[2:1] == 2'b01);
      default:  unsupported = 1'b1;
    endcase
  end

  always_comb begin
    case (ex_q.funct3)
      3'b000:  cond = (rs1_fwd == rs2_fwd);
      3'b001:  cond = (rs1_fwd != rs2_fwd);
      3'b100:  cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      3'b101:  cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      3'b110:  cond = (rs1_fwd <  rs2_fwd);
      3'b111:  cond = (rs1_fwd >= rs2_fwd);
      default: cond = 1'b0;
    endcase
  end

  assign halt_ex = ex_q.valid && unsupported;
  assign taken   = ex_q.valid && !unsupported &&
                   ((ex_q.opcode == OpJal) || (ex_q.opcode == OpJalr) ||
                    ((ex_q.opcode == OpBranch) && cond));

  always_comb begin
    if (!ex_q.valid) begin
      target = 32'd0;
    end else if (ex_q.opcode == OpJal) begin
      target = ex_q.pc + ex_q.imm_uj;
    end else if (ex_q.opcode == OpJalr) begin
      target = (rs1_fwd + ex_q.imm_i) & ~32'd1;
    end else begin
      target = ex_q.pc + ex_q.imm_sb;
    end
  end

  assign bus.EX_ALUResult               = alu_result;
  assign bus.EX_DataRS2                 = rs2_fwd;
  assign bus.EX_rd                      = ex_q.rd;
  assign bus.EX_funct3                  = ex_q.funct3;
  assign bus.EX_DataSize                = ex_q.funct3[1:0];
  assign bus.EX_RWEN                    = !(ex_q.valid && !ex_q.rwen && !halt_ex);
  assign bus.EX_DWEN                    = !(ex_q.valid && !ex_q.dwen && !halt_ex);
  assign bus.EX_MEMREAD                 = ex_q.valid && ex_q.memread && !halt_ex;
  assign bus.EX_BRANCH_OR_JUMP          = ex_q.valid && ex_q.boj;
  assign bus.branch_flag                = taken;
  assign bus.branch_or_jump_target_addr = target;
  assign bus.halt_EX                    = halt_ex;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, forwarding, ALU ops, branch/jump redirect,
// stall/halt_MEM hold and halt_EX latching.
module tb_execute_stage;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  execute_stage_if bus ();

  execute_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Harmless ADDI x0 with every enable inactive and forwarding sources quiet.
  task automatic id_nop();
    bus.ID_PC = 32'h0;        bus.ID_DataRS1 = 32'h0;  bus.ID_DataRS2 = 32'h0;
    bus.ID_imm_I = 32'h0;     bus.ID_imm_S = 32'h0;    bus.ID_imm_SB = 32'h0;
    bus.ID_imm_U = 32'h0;     bus.ID_imm_UJ = 32'h0;
    bus.ID_opcode = 7'b0010011; bus.ID_funct7 = 7'h0;  bus.ID_funct3 = 3'h0;
    bus.ID_rs1 = 5'd0;        bus.ID_rs2 = 5'd0;       bus.ID_rd = 5'd0;
    bus.ID_RWEN = 1'b1;       bus.ID_DWEN = 1'b1;
    bus.ID_MEMREAD = 1'b0;    bus.ID_BRANCH_OR_JUMP = 1'b0;
    bus.EX_stall = 1'b0;      bus.halt_MEM = 1'b0;
    bus.MEM_rd = 5'd0;        bus.MEM_RWEN = 1'b1;     bus.MEM_ALUResult = 32'h0;
    bus.WB_rd = 5'd0;         bus.WB_RWEN = 1'b1;      bus.WB_DataInRd = 32'h0;
  endtask

  // Register-register op on x10/x11 -> x12, no forwarding.
  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    id_nop();
    bus.ID_opcode = opc; bus.ID_funct3 = f3; bus.ID_funct7 = f7;
    bus.ID_rs1 = 5'd10;  bus.ID_rs2 = 5'd11; bus.ID_rd = 5'd12;
    bus.ID_DataRS1 = a;  bus.ID_DataRS2 = b; bus.ID_imm_I = imm;
    bus.ID_RWEN = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    vectors = 0;
    miscompares = 0;

    // Reset with junk on ID.
    rst = 1'b1;
    id_nop();
    bus.ID_opcode = 7'b1110011; bus.ID_PC = 32'h1234; bus.ID_RWEN = 1'b0;
    bus.ID_MEMREAD = 1'b1; bus.ID_BRANCH_OR_JUMP = 1'b1; bus.ID_rd = 5'd9;
    bus.ID_DataRS2 = 32'hdead; bus.ID_rs2 = 5'd3;
    tick();
    tick();
    check("rst_rwen",   bus.EX_RWEN, 1);
    check("rst_dwen",   bus.EX_DWEN, 1);
    check("rst_memrd",  bus.EX_MEMREAD, 0);
    check("rst_boj",    bus.EX_BRANCH_OR_JUMP, 0);
    check("rst_bflag",  bus.branch_flag, 0);
    check("rst_halt",   bus.halt_EX, 0);
    check("rst_alu",    bus.EX_ALUResult, 0);
    check("rst_rs2",    bus.EX_DataRS2, 0);
    check("rst_rd",     bus.EX_rd, 0);
    check("rst_target", bus.branch_or_jump_target_addr, 0);

    // Forwarding: ADD x5 = x1 + x2, MEM supplies x1.
    rst = 1'b0;
    id_nop();
    bus.ID_opcode = 7'b0110011; bus.ID_rs1 = 5'd1; bus.ID_rs2 = 5'd2; bus.ID_rd = 5'd5;
    bus.ID_DataRS1 = 32'd3; bus.ID_DataRS2 = 32'd4; bus.ID_RWEN = 1'b0;
    bus.MEM_rd = 5'd1; bus.MEM_RWEN = 1'b0; bus.MEM_ALUResult = 32'd10;
    tick();
    check("fwd_mem", bus.EX_ALUResult, 14);
    check("fwd_rwen", bus.EX_RWEN, 0);
    check("fwd_rd", bus.EX_rd, 5);
    bus.WB_rd = 5'd1; bus.WB_RWEN = 1'b0; bus.WB_DataInRd = 32'd99;
    #1;
    check("fwd_mem_prio", bus.EX_ALUResult, 14);
    bus.MEM_RWEN = 1'b1;
    #1;
    check("fwd_wb", bus.EX_ALUResult, 103);

    // x0 never forwards.
    id_nop();
    bus.ID_opcode = 7'b0110011; bus.ID_rs1 = 5'd0; bus.ID_rs2 = 5'd2; bus.ID_rd = 5'd5;
    bus.ID_DataRS1 = 32'd3; bus.ID_DataRS2 = 32'd4; bus.ID_RWEN = 1'b0;
    bus.MEM_rd = 5'd0; bus.MEM_RWEN = 1'b0; bus.MEM_ALUResult = 32'd10;
    bus.WB_rd = 5'd0; bus.WB_RWEN = 1'b0; bus.WB_DataInRd = 32'd99;
    tick();
    check("fwd_x0", bus.EX_ALUResult, 7);
    bus.MEM_rd = 5'd2;
    #1;
    check("fwd_rs2_alu", bus.EX_ALUResult, 13);
    check("fwd_rs2_data", bus.EX_DataRS2, 10);

    // BNE taken, then the following edge is a bubble.
    id_nop();
    bus.ID_opcode = 7'b1100011; bus.ID_funct3 = 3'b001; bus.ID_rs1 = 5'd3; bus.ID_rs2 = 5'd4;
    bus.ID_DataRS1 = 32'd1; bus.ID_DataRS2 = 32'd2; bus.ID_PC = 32'h40;
    bus.ID_imm_SB = 32'hFFFF_FFF8; bus.ID_BRANCH_OR_JUMP = 1'b1;
    tick();
    check("bne_flag", bus.branch_flag, 1);
    check("bne_target", bus.branch_or_jump_target_addr, 32'h38);
    check("bne_boj", bus.EX_BRANCH_OR_JUMP, 1);
    set_op(7'b0110011, 3'b000, 7'h0, 32'd1, 32'd1, 32'd0);
    bus.ID_DWEN = 1'b0;
    tick();
    check("flush_rwen", bus.EX_RWEN, 1);
    check("flush_dwen", bus.EX_DWEN, 1);
    check("flush_flag", bus.branch_flag, 0);

    // JALR, then a JAL squashed by its redirect and re-presented.
    id_nop();
    bus.ID_opcode = 7'b1100111; bus.ID_rs1 = 5'd6; bus.ID_DataRS1 = 32'h1001;
    bus.ID_imm_I = 32'd2; bus.ID_PC = 32'h100; bus.ID_rd = 5'd1; bus.ID_RWEN = 1'b0;
    bus.ID_BRANCH_OR_JUMP = 1'b1;
    tick();
    check("jalr_target", bus.branch_or_jump_target_addr, 32'h1002);
    check("jalr_link", bus.EX_ALUResult, 32'h104);
    check("jalr_flag", bus.branch_flag, 1);
    id_nop();
    bus.ID_opcode = 7'b1101111; bus.ID_PC = 32'h200; bus.ID_imm_UJ = 32'h10;
    bus.ID_rd = 5'd1; bus.ID_RWEN = 1'b0; bus.ID_BRANCH_OR_JUMP = 1'b1;
    tick();
    check("jal_squash_flag", bus.branch_flag, 0);
    check("jal_squash_rwen", bus.EX_RWEN, 1);
    tick();
    check("jal_flag", bus.branch_flag, 1);
    check("jal_target", bus.branch_or_jump_target_addr, 32'h210);
    check("jal_link", bus.EX_ALUResult, 32'h204);
    id_nop();
    tick();
    tick();

    // Arithmetic edges.
    set_op(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31, 32'd0);
    tick();
    check("sra", bus.EX_ALUResult, 32'hFFFF_FFFF);
    set_op(7'b0110011, 3'b011, 7'h0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    check("sltu", bus.EX_ALUResult, 1);
    set_op(7'b0110011, 3'b010, 7'h0, 32'd1, 32'hFFFF_FFFF, 32'd0);
    tick();
    check("slt", bus.EX_ALUResult, 0);
    set_op(7'b0110011, 3'b000, 7'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    tick();
    check("add_wrap", bus.EX_ALUResult, 0);
    set_op(7'b0110011, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd0);
    tick();
    check("sub", bus.EX_ALUResult, 32'hFFFF_FFFE);
    set_op(7'b0010011, 3'b101, 7'b0100000, 32'hF000_0000, 32'd0, 32'd4);
    tick();
    check("srai", bus.EX_ALUResult, 32'hFF00_0000);
    set_op(7'b0010011, 3'b000, 7'b0100000, 32'd10, 32'd0, 32'hFFFF_FFFD);
    tick();
    check("addi_f7", bus.EX_ALUResult, 7);

    // Load / store address and store data.
    set_op(7'b0000011, 3'b010, 7'h0, 32'h1000, 32'd0, 32'h20);
    bus.ID_MEMREAD = 1'b1;
    tick();
    check("load_addr", bus.EX_ALUResult, 32'h1020);
    check("load_memrd", bus.EX_MEMREAD, 1);
    check("load_size", bus.EX_DataSize, 2);
    set_op(7'b0100011, 3'b001, 7'h0, 32'h2000, 32'hABCD, 32'd0);
    bus.ID_imm_S = 32'hFFFF_FFFC; bus.ID_RWEN = 1'b1; bus.ID_DWEN = 1'b0;
    tick();
    check("store_addr", bus.EX_ALUResult, 32'h1FFC);
    check("store_data", bus.EX_DataRS2, 32'hABCD);
    check("store_dwen", bus.EX_DWEN, 0);
    check("store_size", bus.EX_DataSize, 1);
    id_nop();
    bus.ID_opcode = 7'b0010111; bus.ID_PC = 32'h1000; bus.ID_imm_U = 32'h2000;
    tick();
    check("auipc", bus.EX_ALUResult, 32'h3000);

    // Load-use stall inserts a bubble.
    set_op(7'b0110011, 3'b000, 7'h0, 32'd1, 32'd1, 32'd0);
    bus.EX_stall = 1'b1;
    tick();
    check("stall_rwen", bus.EX_RWEN, 1);
    check("stall_alu", bus.EX_ALUResult, 0);
    bus.EX_stall = 1'b0;
    tick();
    check("after_stall", bus.EX_ALUResult, 2);

    // halt_MEM freezes EX.
    id_nop();
    bus.ID_opcode = 7'b0110111; bus.ID_imm_U = 32'h1234_5000; bus.ID_rd = 5'd9;
    bus.ID_RWEN = 1'b0;
    tick();
    check("lui", bus.EX_ALUResult, 32'h1234_5000);
    set_op(7'b0110011, 3'b000, 7'h0, 32'd5, 32'd5, 32'd0);
    bus.ID_rd = 5'd3;
    bus.halt_MEM = 1'b1;
    tick();
    tick();
    check("hmem_alu", bus.EX_ALUResult, 32'h1234_5000);
    check("hmem_rd", bus.EX_rd, 9);
    bus.halt_MEM = 1'b0;
    tick();
    check("hmem_release", bus.EX_ALUResult, 10);

    // Unsupported opcode: halt_EX latches and EX freezes.
    id_nop();
    bus.ID_opcode = 7'b1110011; bus.ID_rd = 5'd7; bus.ID_RWEN = 1'b0; bus.ID_MEMREAD = 1'b1;
    tick();
    check("halt_set", bus.halt_EX, 1);
    check("halt_rwen", bus.EX_RWEN, 1);
    check("halt_memrd", bus.EX_MEMREAD, 0);
    check("halt_flag", bus.branch_flag, 0);
    for (int i = 0; i < 5; i++) begin
      set_op(7'b0110011, 3'b000, 7'h0, i, i, 32'd0);
      bus.ID_rd = 5'(i + 20);
      tick();
      check("halt_hold", bus.halt_EX, 1);
      check("halt_rd", bus.EX_rd, 7);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_clear", bus.halt_EX, 0);
    check("halt_clear_rwen", bus.EX_RWEN, 1);

    // Branch with reserved funct3 halts too.
    id_nop();
    bus.ID_opcode = 7'b1100011; bus.ID_funct3 = 3'b010; bus.ID_BRANCH_OR_JUMP = 1'b1;
    tick();
    check("br010_halt", bus.halt_EX, 1);
    check("br010_flag", bus.branch_flag, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("br010_clear", bus.halt_EX, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
